// File: rtl/input_line_packer_if.sv
// Pixel-stream and line-buffer write signals of the input line packer.
// The packer itself uses the slave view; the source/sink side uses master.
interface input_line_packer_if #(
    parameter int CHANNEL_COUNT   = 3,
    parameter int BATCH_SIZE      = 4,
    parameter int MAX_WIDTH       = 1920,
    parameter int MAX_HEIGHT      = 1080,
    parameter int ROWS_PER_BUFFER = 8
);
    localparam int WORDS_PER_ROW = (MAX_WIDTH + BATCH_SIZE - 1) / BATCH_SIZE;
    localparam int ADDR_BITS     = $clog2(ROWS_PER_BUFFER * WORDS_PER_ROW);
    localparam int XB            = $clog2(MAX_WIDTH);
    localparam int ROW_BITS      = (ROWS_PER_BUFFER > 1) ? $clog2(ROWS_PER_BUFFER) : 1;
    localparam int LCB           = $clog2(MAX_HEIGHT) + 1;

    logic                                  I_rgb_de;
    logic                                  I_rgb_vs;
    logic [8*CHANNEL_COUNT-1:0]            I_rgb_color;
    logic [XB-1:0]                         I_crop_x0;
    logic [XB:0]                           I_crop_w;
    logic [8*BATCH_SIZE*CHANNEL_COUNT-1:0] O_data_flat;
    logic [ADDR_BITS-1:0]                  O_address;
    logic                                  O_write_enable;
    logic [ROW_BITS-1:0]                   O_row;
    logic                                  O_buffer_sel;
    logic                                  O_swap_trigger;
    logic                                  O_frame_start;
    logic [XB:0]                           O_line_width;
    logic [LCB-1:0]                        O_line_count;

    modport master (
        output I_rgb_de, I_rgb_vs, I_rgb_color, I_crop_x0, I_crop_w,
        input  O_data_flat, O_address, O_write_enable, O_row, O_buffer_sel,
               O_swap_trigger, O_frame_start, O_line_width, O_line_count
    );

    modport slave (
        input  I_rgb_de, I_rgb_vs, I_rgb_color, I_crop_x0, I_crop_w,
        output O_data_flat, O_address, O_write_enable, O_row, O_buffer_sel,
               O_swap_trigger, O_frame_start, O_line_width, O_line_count
    );
endinterface

// File: rtl/input_line_packer.sv
// Crops each video line, packs BATCH_SIZE pixels per line-buffer word, flushes
// partial batches at line end and swaps buffer halves every ROWS_PER_BUFFER rows.
module input_line_packer #(
    parameter int CHANNEL_COUNT   = 3,
    parameter int BATCH_SIZE      = 4,
    parameter int MAX_WIDTH       = 1920,
    parameter int MAX_HEIGHT      = 1080,
    parameter int ROWS_PER_BUFFER = 8
) (
    input  logic               I_rgb_clk,
    input  logic               I_rst,
    input_line_packer_if.slave bus
);
    localparam int WORDS_PER_ROW = (MAX_WIDTH + BATCH_SIZE - 1) / BATCH_SIZE;
    localparam int ADDR_BITS     = $clog2(ROWS_PER_BUFFER * WORDS_PER_ROW);
    localparam int XB            = $clog2(MAX_WIDTH);
    localparam int WB            = XB + 1;
    localparam int KB            = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int BIB           = $clog2(WORDS_PER_ROW + 1);
    localparam int ROW_BITS      = (ROWS_PER_BUFFER > 1) ? $clog2(ROWS_PER_BUFFER) : 1;
    localparam int LCB           = $clog2(MAX_HEIGHT) + 1;
    localparam int WORD_BITS     = 8 * BATCH_SIZE * CHANNEL_COUNT;

    localparam logic [WB-1:0]        X_MAX    = WB'(MAX_WIDTH);
    localparam logic [KB-1:0]        K_LAST   = KB'(BATCH_SIZE - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(ROWS_PER_BUFFER - 1);
    localparam logic [ADDR_BITS-1:0] STRIDE   = ADDR_BITS'(WORDS_PER_ROW);

    logic                 de_q, de_d, vs_q, vs_d;
    logic [WB-1:0]        x_q, x_d, w_q, w_d;
    logic [XB-1:0]        x0_q, x0_d;
    logic [KB-1:0]        k_q, k_d;
    logic [BIB-1:0]       bidx_q, bidx_d;
    logic [WORD_BITS-1:0] lanes_q, lanes_d, lanes_fill;
    logic                 acc_line_q, acc_line_d, abort_q, abort_d, adv_q, adv_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic                 bsel_q, bsel_d, swap_q, swap_d, fs_q, fs_d, we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d, wr_addr;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic [WB-1:0]        width_q, width_d;
    logic [LCB-1:0]       lc_q, lc_d;

    logic          line_start, line_end, vs_rise, accept, aborted;
    logic [WB-1:0] x_cur, w_cur;
    logic [XB-1:0] x0_cur;
    logic [WB:0]   win_end;

    assign line_start = bus.I_rgb_de & ~de_q;
    assign line_end   = ~bus.I_rgb_de & de_q;
    assign vs_rise    = bus.I_rgb_vs & ~vs_q;
    assign aborted    = abort_q & ~line_start;

    // Crop settings are taken straight from the ports on the line-start cycle.
    assign x_cur   = line_start ? '0 : x_q;
    assign x0_cur  = line_start ? bus.I_crop_x0 : x0_q;
    assign w_cur   = line_start ? bus.I_crop_w : w_q;
    assign win_end = (WB+1)'(x0_cur) + (WB+1)'(w_cur);
    assign accept  = bus.I_rgb_de && !aborted && !vs_rise
                     && (x_cur >= WB'(x0_cur))
                     && ((w_cur == '0) || ((WB+1)'(x_cur) < win_end))
                     && (x_cur < X_MAX);
    assign wr_addr = (ADDR_BITS'(row_q) * STRIDE) + ADDR_BITS'(bidx_q);

    always_comb begin
        lanes_fill = lanes_q;
        for (int c = 0; c < CHANNEL_COUNT; c++)
            lanes_fill[c*8*BATCH_SIZE + 8*int'(k_q) +: 8] = bus.I_rgb_color[8*c +: 8];
    end

    always_comb begin
        de_d       = bus.I_rgb_de;
        vs_d       = bus.I_rgb_vs;
        x_d        = x_q;
        x0_d       = x0_q;
        w_d        = w_q;
        k_d        = k_q;
        bidx_d     = bidx_q;
        lanes_d    = lanes_q;
        acc_line_d = acc_line_q;
        abort_d    = (vs_rise & bus.I_rgb_de) | aborted;
        adv_d      = 1'b0;
        row_d      = row_q;
        bsel_d     = bsel_q;
        swap_d     = 1'b0;
        fs_d       = vs_rise;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        width_d    = width_q;
        lc_d       = lc_q;

        if (line_start) begin
            x0_d       = bus.I_crop_x0;
            w_d        = bus.I_crop_w;
            acc_line_d = 1'b0;
        end
        if (bus.I_rgb_de)
            x_d = line_start ? WB'(1) : ((x_q == X_MAX) ? x_q : x_q + 1'b1);

        if (accept) begin
            acc_line_d = 1'b1;
            if (k_q == K_LAST) begin
                we_d    = 1'b1;
                data_d  = lanes_fill;
                addr_d  = wr_addr;
                lanes_d = '0;
                k_d     = '0;
                bidx_d  = bidx_q + 1'b1;
            end else begin
                lanes_d = lanes_fill;
                k_d     = k_q + 1'b1;
            end
        end

        // Flush runs on the old row/batch so a new line may start next cycle.
        if (line_end) begin
            width_d = x_q;
            if (!abort_q) begin
                if (k_q != '0) begin
                    we_d   = 1'b1;
                    data_d = lanes_q;
                    addr_d = wr_addr;
                end
                if (lc_q != '1)
                    lc_d = lc_q + 1'b1;
                adv_d = acc_line_q;
            end
            k_d     = '0;
            bidx_d  = '0;
            lanes_d = '0;
        end

        if (adv_q) begin
            if (row_q == ROW_LAST) begin
                row_d  = '0;
                bsel_d = ~bsel_q;
                swap_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end

        if (vs_rise) begin
            k_d     = '0;
            bidx_d  = '0;
            lanes_d = '0;
            row_d   = '0;
            lc_d    = '0;
            adv_d   = 1'b0;
            we_d    = 1'b0;
            swap_d  = 1'b0;
            bsel_d  = bsel_q;
        end
    end

    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        if (I_rst) begin
            de_q <= 1'b0;  vs_q <= 1'b0;  x_q <= '0;  x0_q <= '0;  w_q <= '0;
            k_q <= '0;  bidx_q <= '0;  lanes_q <= '0;  acc_line_q <= 1'b0;
            abort_q <= 1'b0;  adv_q <= 1'b0;  row_q <= '0;  bsel_q <= 1'b0;
            swap_q <= 1'b0;  fs_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;
            data_q <= '0;  width_q <= '0;  lc_q <= '0;
        end else begin
            de_q <= de_d;  vs_q <= vs_d;  x_q <= x_d;  x0_q <= x0_d;  w_q <= w_d;
            k_q <= k_d;  bidx_q <= bidx_d;  lanes_q <= lanes_d;  acc_line_q <= acc_line_d;
            abort_q <= abort_d;  adv_q <= adv_d;  row_q <= row_d;  bsel_q <= bsel_d;
            swap_q <= swap_d;  fs_q <= fs_d;  we_q <= we_d;  addr_q <= addr_d;
            data_q <= data_d;  width_q <= width_d;  lc_q <= lc_d;
        end
    end

    assign bus.O_data_flat    = data_q;
    assign bus.O_address      = addr_q;
    assign bus.O_write_enable = we_q;
    assign bus.O_row          = row_q;
    assign bus.O_buffer_sel   = bsel_q;
    assign bus.O_swap_trigger = swap_q;
    assign bus.O_frame_start  = fs_q;
    assign bus.O_line_width   = width_q;
    assign bus.O_line_count   = lc_q;
endmodule
